// File: rtl/rv32_pkg.sv
// Shared RV32IM definitions: ALU operation codes (also used by decode's control unit),
// divider FSM states and the divider iteration count.
package rv32_pkg;

    // Radix-2 divider: one quotient bit per iteration.
    localparam int unsigned DIV_ITER  = 32;
    localparam int unsigned DIV_CNT_W = $clog2(DIV_ITER);

    typedef enum logic [4:0] {
        AluAdd    = 5'd0,
        AluSub    = 5'd1,
        AluSll    = 5'd2,
        AluSlt    = 5'd3,
        AluSltu   = 5'd4,
        AluXor    = 5'd5,
        AluSrl    = 5'd6,
        AluSra    = 5'd7,
        AluOr     = 5'd8,
        AluAnd    = 5'd9,
        AluPassb  = 5'd10,
        AluMul    = 5'd11,
        AluMulh   = 5'd12,
        AluMulhsu = 5'd13,
        AluMulhu  = 5'd14,
        AluDiv    = 5'd15,
        AluDivu   = 5'd16,
        AluRem    = 5'd17,
        AluRemu   = 5'd18
    } alu_op_t;

    typedef enum logic [1:0] {
        DivIdle,
        DivCalc,
        DivFin
    } div_state_t;

endpackage

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   start           accepted div-class op (only honoured in idle)
//   flush           abort an in-flight op; no done pulse for it
//   op_signed       DIV/REM (operands are two's complement)
//   op_rem          REM/REMU (return remainder instead of quotient)
//   dividend        operand A
//   divisor         operand B
//   busy            registered: state != idle
//   done            combinational: result valid this cycle (fast path or FIN)
//   result          combinational result accompanying done
module div_unit
    import rv32_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  flush,
    input  logic                  op_signed,
    input  logic                  op_rem,
    input  logic [DATA_WIDTH-1:0] dividend,
    input  logic [DATA_WIDTH-1:0] divisor,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result
);

    localparam logic [DATA_WIDTH-1:0] INT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    div_state_t             state_q, state_d;
    logic [DIV_CNT_W-1:0]   count_q, count_d;
    logic [DATA_WIDTH-1:0]  quo_q, quo_d;
    logic [DATA_WIDTH-1:0]  rem_q, rem_d;
    logic [DATA_WIDTH-1:0]  dvsr_q, dvsr_d;
    logic                   neg_quo_q, neg_quo_d;
    logic                   neg_rem_q, neg_rem_d;
    logic                   want_rem_q, want_rem_d;

    logic                   a_neg, b_neg;
    logic [DATA_WIDTH-1:0]  a_abs, b_abs;
    logic                   div_zero, overflow;
    logic [DATA_WIDTH:0]    trial_shift, trial_diff;

    assign a_neg    = op_signed & dividend[DATA_WIDTH-1];
    assign b_neg    = op_signed & divisor[DATA_WIDTH-1];
    assign a_abs    = a_neg ? ('0 - dividend) : dividend;
    assign b_abs    = b_neg ? ('0 - divisor) : divisor;
    assign div_zero = (divisor == '0);
    assign overflow = op_signed & (dividend == INT_MIN) & (divisor == '1);

    // Shift the next dividend bit into the partial remainder and try to subtract.
    // The partial remainder is always below the divisor, so W+1 bits suffice.
    assign trial_shift = {rem_q, quo_q[DATA_WIDTH-1]};
    assign trial_diff  = trial_shift - {1'b0, dvsr_q};

    assign busy = (state_q != DivIdle);

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        quo_d      = quo_q;
        rem_d      = rem_q;
        dvsr_d     = dvsr_q;
        neg_quo_d  = neg_quo_q;
        neg_rem_d  = neg_rem_q;
        want_rem_d = want_rem_q;
        done       = 1'b0;
        result     = '0;

        unique case (state_q)
            DivIdle: begin
                if (start) begin
                    if (div_zero) begin
                        done   = 1'b1;
                        result = op_rem ? dividend : '1;
                    end else if (overflow) begin
                        done   = 1'b1;
                        result = op_rem ? '0 : INT_MIN;
                    end else begin
                        state_d    = DivCalc;
                        count_d    = '0;
                        quo_d      = a_abs;
                        rem_d      = '0;
                        dvsr_d     = b_abs;
                        neg_quo_d  = a_neg ^ b_neg;
                        neg_rem_d  = a_neg;
                        want_rem_d = op_rem;
                    end
                end
            end
            DivCalc: begin
                if (!trial_diff[DATA_WIDTH]) begin
                    rem_d = trial_diff[DATA_WIDTH-1:0];
                    quo_d = {quo_q[DATA_WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = trial_shift[DATA_WIDTH-1:0];
                    quo_d = {quo_q[DATA_WIDTH-2:0], 1'b0};
                end
                count_d = count_q + 1'b1;
                if (count_q == DIV_CNT_W'(DIV_ITER - 1)) begin
                    state_d = DivFin;
                end
                if (flush) begin
                    state_d = DivIdle;
                end
            end
            DivFin: begin
                state_d = DivIdle;
                if (want_rem_q) begin
                    result = neg_rem_q ? ('0 - rem_q) : rem_q;
                end else begin
                    result = neg_quo_q ? ('0 - quo_q) : quo_q;
                end
                // A flush arriving together with completion kills the result.
                done = ~flush;
            end
            default: begin
                state_d = DivIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= DivIdle;
            count_q    <= '0;
            quo_q      <= '0;
            rem_q      <= '0;
            dvsr_q     <= '0;
            neg_quo_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            want_rem_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            quo_q      <= quo_d;
            rem_q      <= rem_d;
            dvsr_q     <= dvsr_d;
            neg_quo_q  <= neg_quo_d;
            neg_rem_q  <= neg_rem_d;
            want_rem_q <= want_rem_d;
        end
    end

endmodule

// File: rtl/execute_stage.sv
// RV32IM execute stage: single-cycle ALU and multiplier, iterative divider.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   ex_valid_i    decode presents a valid operation
//   alu_control   operation code (rv32_pkg::alu_op_t; unused codes yield 0)
//   opa_mux_out   operand A
//   opb_mux_out   operand B
//   flush_i       kill in-flight divide / suppress acceptance
//   busy_o        divider occupied; upstream holds its instruction
//   ex_valid_o    one-cycle pulse per completed op
//   ex_result     registered result, held between pulses
module execute_stage
    import rv32_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ALU_CONTROL = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ex_valid_i,
    input  logic [ALU_CONTROL-1:0] alu_control,
    input  logic [DATA_WIDTH-1:0]  opa_mux_out,
    input  logic [DATA_WIDTH-1:0]  opb_mux_out,
    input  logic                   flush_i,
    output logic                   busy_o,
    output logic                   ex_valid_o,
    output logic [DATA_WIDTH-1:0]  ex_result
);

    alu_op_t                 op;
    logic                    accept, is_div, alu_fire, div_start;
    logic                    div_busy, div_done;
    logic [DATA_WIDTH-1:0]   div_result;
    logic [DATA_WIDTH-1:0]   alu_result;
    logic                    mul_a_sgn, mul_b_sgn;
    logic [2*DATA_WIDTH-1:0] mul_a, mul_b, mul_prod;
    logic [4:0]              shamt;
    logic                    valid_q;
    logic [DATA_WIDTH-1:0]   result_q;

    assign op        = alu_op_t'(alu_control);
    assign is_div    = op inside {AluDiv, AluDivu, AluRem, AluRemu};
    assign accept    = ex_valid_i & ~div_busy & ~flush_i;
    assign alu_fire  = accept & ~is_div;
    assign div_start = accept & is_div;
    assign shamt     = opb_mux_out[4:0];

    // Extend both operands to 2W bits with per-op signedness; the low 2W bits
    // of the product are then correct for every MUL variant.
    assign mul_a_sgn = (op == AluMulh) | (op == AluMulhsu);
    assign mul_b_sgn = (op == AluMulh);
    assign mul_a     = {{DATA_WIDTH{mul_a_sgn & opa_mux_out[DATA_WIDTH-1]}}, opa_mux_out};
    assign mul_b     = {{DATA_WIDTH{mul_b_sgn & opb_mux_out[DATA_WIDTH-1]}}, opb_mux_out};
    assign mul_prod  = mul_a * mul_b;

    always_comb begin
        alu_result = '0;
        case (op)
            AluAdd:    alu_result = opa_mux_out + opb_mux_out;
            AluSub:    alu_result = opa_mux_out - opb_mux_out;
            AluSll:    alu_result = opa_mux_out << shamt;
            AluSlt:    alu_result = {{(DATA_WIDTH-1){1'b0}},
                                     ($signed(opa_mux_out) < $signed(opb_mux_out))};
            AluSltu:   alu_result = {{(DATA_WIDTH-1){1'b0}}, (opa_mux_out < opb_mux_out)};
            AluXor:    alu_result = opa_mux_out ^ opb_mux_out;
            AluSrl:    alu_result = opa_mux_out >> shamt;
            AluSra:    alu_result = $unsigned($signed(opa_mux_out) >>> shamt);
            AluOr:     alu_result = opa_mux_out | opb_mux_out;
            AluAnd:    alu_result = opa_mux_out & opb_mux_out;
            AluPassb:  alu_result = opb_mux_out;
            AluMul:    alu_result = mul_prod[DATA_WIDTH-1:0];
            AluMulh,
            AluMulhsu,
            AluMulhu:  alu_result = mul_prod[2*DATA_WIDTH-1:DATA_WIDTH];
            default:   alu_result = '0;
        endcase
    end

    div_unit #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_div_unit (
        .clk       (clk),
        .rst       (rst),
        .start     (div_start),
        .flush     (flush_i),
        .op_signed ((op == AluDiv) | (op == AluRem)),
        .op_rem    ((op == AluRem) | (op == AluRemu)),
        .dividend  (opa_mux_out),
        .divisor   (opb_mux_out),
        .busy      (div_busy),
        .done      (div_done),
        .result    (div_result)
    );

    // alu_fire and div_done never coincide: div_done outside the idle fast path
    // only occurs while busy, which blocks acceptance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q  <= 1'b0;
            result_q <= '0;
        end else begin
            valid_q <= alu_fire | div_done;
            if (alu_fire) begin
                result_q <= alu_result;
            end else if (div_done) begin
                result_q <= div_result;
            end
        end
    end

    assign busy_o     = div_busy;
    assign ex_valid_o = valid_q;
    assign ex_result  = result_q;

endmodule

// File: tb/tb_execute_stage.sv
// Directed self-checking bench for execute_stage.
module tb_execute_stage;

    logic        clk;
    logic        rst;
    logic        ex_valid_i;
    logic [4:0]  alu_control;
    logic [31:0] opa_mux_out;
    logic [31:0] opb_mux_out;
    logic        flush_i;
    logic        busy_o;
    logic        ex_valid_o;
    logic [31:0] ex_result;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[$];

    execute_stage #(
        .DATA_WIDTH  (32),
        .ALU_CONTROL (5)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ex_valid_i  (ex_valid_i),
        .alu_control (alu_control),
        .opa_mux_out (opa_mux_out),
        .opb_mux_out (opb_mux_out),
        .flush_i     (flush_i),
        .busy_o      (busy_o),
        .ex_valid_o  (ex_valid_o),
        .ex_result   (ex_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        ex_valid_i  = 1'b1;
        alu_control = op;
        opa_mux_out = a;
        opb_mux_out = b;
    endtask

    // Issue a div-class op and follow it to completion (bounded). When poke is
    // set, offer an ADD during the first busy cycles; it must be ignored.
    task automatic run_div(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                           input bit poke, output int busy_cnt, output int valid_at,
                           output logic [31:0] res);
        busy_cnt = 0;
        valid_at = 0;
        res      = '0;
        drive(op, a, b);
        tick();
        for (int k = 1; k <= 40; k++) begin
            if (busy_o) busy_cnt++;
            if (ex_valid_o) begin
                valid_at = k;
                res      = ex_result;
                break;
            end
            if (poke && k <= 4) drive(5'd0, 32'd1, 32'd1);
            else ex_valid_i = 1'b0;
            tick();
        end
        ex_valid_i = 1'b0;
    endtask

    initial begin
        int          bc, va, nv;
        logic [31:0] res;

        rst         = 1'b1;
        ex_valid_i  = 1'b0;
        flush_i     = 1'b0;
        alu_control = '0;
        opa_mux_out = '0;
        opb_mux_out = '0;
        tick();
        tick();
        check_eq("reset busy", {31'd0, busy_o}, 32'd0);
        check_eq("reset valid", {31'd0, ex_valid_o}, 32'd0);
        check_eq("reset result", ex_result, 32'd0);
        rst = 1'b0;
        tick();

        vecs.push_back('{op: 5'd0,  a: 32'h7FFFFFFF, b: 32'h00000001, exp: 32'h80000000});
        vecs.push_back('{op: 5'd1,  a: 32'h00000005, b: 32'h00000007, exp: 32'hFFFFFFFE});
        vecs.push_back('{op: 5'd2,  a: 32'h00000001, b: 32'h00000023, exp: 32'h00000008});
        vecs.push_back('{op: 5'd3,  a: 32'hFFFFFFFF, b: 32'h00000001, exp: 32'h00000001});
        vecs.push_back('{op: 5'd3,  a: 32'h00000001, b: 32'hFFFFFFFF, exp: 32'h00000000});
        vecs.push_back('{op: 5'd4,  a: 32'h00000001, b: 32'hFFFFFFFF, exp: 32'h00000001});
        vecs.push_back('{op: 5'd5,  a: 32'h0000F0F0, b: 32'h0000FF00, exp: 32'h00000FF0});
        vecs.push_back('{op: 5'd6,  a: 32'h80000000, b: 32'h0000001F, exp: 32'h00000001});
        vecs.push_back('{op: 5'd7,  a: 32'h80000000, b: 32'h0000001F, exp: 32'hFFFFFFFF});
        vecs.push_back('{op: 5'd7,  a: 32'h80000000, b: 32'h00000024, exp: 32'hF8000000});
        vecs.push_back('{op: 5'd8,  a: 32'h00000F00, b: 32'h000000F0, exp: 32'h00000FF0});
        vecs.push_back('{op: 5'd9,  a: 32'h00000FF0, b: 32'h000000FF, exp: 32'h000000F0});
        vecs.push_back('{op: 5'd10, a: 32'hDEADBEEF, b: 32'h12345000, exp: 32'h12345000});
        vecs.push_back('{op: 5'd11, a: 32'hFFFFFFFF, b: 32'hFFFFFFFF, exp: 32'h00000001});
        vecs.push_back('{op: 5'd11, a: 32'h00010000, b: 32'h00010000, exp: 32'h00000000});
        vecs.push_back('{op: 5'd12, a: 32'hFFFFFFFF, b: 32'hFFFFFFFF, exp: 32'h00000000});
        vecs.push_back('{op: 5'd13, a: 32'hFFFFFFFF, b: 32'h00000002, exp: 32'hFFFFFFFF});
        vecs.push_back('{op: 5'd14, a: 32'hFFFFFFFF, b: 32'hFFFFFFFF, exp: 32'hFFFFFFFE});
        vecs.push_back('{op: 5'd25, a: 32'h00000005, b: 32'h00000005, exp: 32'h00000000});
        vecs.push_back('{op: 5'd16, a: 32'h00000005, b: 32'h00000000, exp: 32'hFFFFFFFF});
        vecs.push_back('{op: 5'd17, a: 32'h00000005, b: 32'h00000000, exp: 32'h00000005});
        vecs.push_back('{op: 5'd17, a: 32'h80000000, b: 32'hFFFFFFFF, exp: 32'h00000000});
        vecs.push_back('{op: 5'd15, a: 32'h80000000, b: 32'hFFFFFFFF, exp: 32'h80000000});

        // Back-to-back single-cycle ops and divider fast paths, one per cycle.
        foreach (vecs[i]) begin
            drive(vecs[i].op, vecs[i].a, vecs[i].b);
            tick();
            check_eq($sformatf("vec%0d op%0d result", i, vecs[i].op), ex_result, vecs[i].exp);
            check_eq($sformatf("vec%0d valid", i), {31'd0, ex_valid_o}, 32'd1);
            check_eq($sformatf("vec%0d busy", i), {31'd0, busy_o}, 32'd0);
        end
        ex_valid_i = 1'b0;
        tick();
        check_eq("idle valid", {31'd0, ex_valid_o}, 32'd0);
        check_eq("idle result hold", ex_result, 32'h80000000);
        check_eq("idle busy", {31'd0, busy_o}, 32'd0);

        // Flush in idle suppresses acceptance.
        drive(5'd0, 32'd2, 32'd3);
        flush_i = 1'b1;
        tick();
        flush_i    = 1'b0;
        ex_valid_i = 1'b0;
        check_eq("idle flush valid", {31'd0, ex_valid_o}, 32'd0);
        check_eq("idle flush result", ex_result, 32'h80000000);

        run_div(5'd15, 32'hFFFFFFF9, 32'd2, 1'b1, bc, va, res);
        check_eq("div busy cycles", bc, 32'd33);
        check_eq("div valid cycle", va, 32'd34);
        check_eq("div -7/2", res, 32'hFFFFFFFD);
        check_eq("div busy at done", {31'd0, busy_o}, 32'd0);

        run_div(5'd17, 32'hFFFFFFF9, 32'd2, 1'b0, bc, va, res);
        check_eq("rem valid cycle", va, 32'd34);
        check_eq("rem -7%2", res, 32'hFFFFFFFF);

        run_div(5'd17, 32'd20, 32'hFFFFFFFD, 1'b0, bc, va, res);
        check_eq("rem 20%-3", res, 32'd2);

        run_div(5'd16, 32'd100, 32'd7, 1'b0, bc, va, res);
        check_eq("divu busy cycles", bc, 32'd33);
        check_eq("divu 100/7", res, 32'd14);
        // A new op is accepted in the completion cycle.
        drive(5'd0, 32'd2, 32'd3);
        tick();
        ex_valid_i = 1'b0;
        check_eq("accept at T+34 valid", {31'd0, ex_valid_o}, 32'd1);
        check_eq("accept at T+34 result", ex_result, 32'd5);

        // Flush during CALC at T+10.
        drive(5'd15, 32'd100, 32'd7);
        tick();
        ex_valid_i = 1'b0;
        repeat (9) tick();
        check_eq("busy before flush", {31'd0, busy_o}, 32'd1);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        check_eq("flush calc busy", {31'd0, busy_o}, 32'd0);
        check_eq("flush calc valid", {31'd0, ex_valid_o}, 32'd0);
        nv = 0;
        for (int k = 0; k < 30; k++) begin
            if (ex_valid_o) nv++;
            tick();
        end
        check_eq("flush calc no pulse", nv, 32'd0);
        check_eq("flush calc result", ex_result, 32'd5);

        // Flush coinciding with FIN at T+33.
        drive(5'd15, 32'd100, 32'd7);
        tick();
        ex_valid_i = 1'b0;
        repeat (32) tick();
        check_eq("busy in fin", {31'd0, busy_o}, 32'd1);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        check_eq("flush fin valid", {31'd0, ex_valid_o}, 32'd0);
        check_eq("flush fin busy", {31'd0, busy_o}, 32'd0);
        tick();
        check_eq("flush fin valid later", {31'd0, ex_valid_o}, 32'd0);
        check_eq("flush fin result", ex_result, 32'd5);

        // Asynchronous reset mid-divide at T+20.
        drive(5'd15, 32'd100, 32'd7);
        tick();
        ex_valid_i = 1'b0;
        repeat (19) tick();
        check_eq("busy before reset", {31'd0, busy_o}, 32'd1);
        rst = 1'b1;
        #1;
        check_eq("async reset busy", {31'd0, busy_o}, 32'd0);
        check_eq("async reset valid", {31'd0, ex_valid_o}, 32'd0);
        check_eq("async reset result", ex_result, 32'd0);
        tick();
        rst = 1'b0;
        drive(5'd0, 32'd2, 32'd3);
        tick();
        ex_valid_i = 1'b0;
        check_eq("post reset add", ex_result, 32'd5);
        check_eq("post reset valid", {31'd0, ex_valid_o}, 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
